// File: rtl/idex_register.sv
// idex_register: ID/EX pipeline register with bubble insertion and optional load-use hazard detection.
// Latency: one clock from every *In to its *Out; hazardStall is combinational from the current *In and *Out.
// Backpressure: stall holds all state; a flush or load-use hazard loads a bubble, counted in bubbleCount.
//
// Optional feature: define IDEX_LOAD_USE_DETECT_EN to enable load-use detection. With it undefined,
// hazardStall is tied to 0 and bubbles come only from flush.
//
// Ports:
//   clk, rst (async, active-high)      clock and reset
//   stall, flush                       hold / bubble-load requests
//   validIn/Out                        instruction-valid flag
//   ALUopIn/Out [1:0]                  ALU op class (to alucontrol)
//   functionCodeIn/Out [3:0]           function field (to alucontrol)
//   ALUSrc, regWrite, memRead,
//   memWrite, memToReg In/Out          control bits
//   readData1, readData2, imm In/Out   16-bit operands and sign-extended immediate
//   rs, rt, rd In/Out [3:0]            register numbers
//   hazardStall                        load-use stall request to PC and IF/ID
//   bubbleCount [7:0]                  saturating count of inserted bubbles
module idex_register (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        validIn,
  input  logic [1:0]  ALUopIn,
  input  logic [3:0]  functionCodeIn,
  input  logic        ALUSrcIn,
  input  logic        regWriteIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic        memToRegIn,
  input  logic [15:0] readData1In,
  input  logic [15:0] readData2In,
  input  logic [15:0] immIn,
  input  logic [3:0]  rsIn,
  input  logic [3:0]  rtIn,
  input  logic [3:0]  rdIn,
  output logic        validOut,
  output logic [1:0]  ALUopOut,
  output logic [3:0]  functionCodeOut,
  output logic        ALUSrcOut,
  output logic        regWriteOut,
  output logic        memReadOut,
  output logic        memWriteOut,
  output logic        memToRegOut,
  output logic [15:0] readData1Out,
  output logic [15:0] readData2Out,
  output logic [15:0] immOut,
  output logic [3:0]  rsOut,
  output logic [3:0]  rtOut,
  output logic [3:0]  rdOut,
  output logic        hazardStall,
  output logic [7:0]  bubbleCount
);

`ifdef IDEX_LOAD_USE_DETECT_EN
  // A load sitting in EX whose destination (rt) is a source of the instruction
  // now in ID. r0 is never a real dependency.
  always_comb begin
    hazardStall = validOut & memReadOut & (rtOut != 4'd0) &
                  ((rtOut == rsIn) | (rtOut == rtIn)) & validIn;
  end
`else
  always_comb begin
    hazardStall = 1'b0;
  end
`endif

  // Bubble edges: flush always wins; a hazard only counts when not stalled, so
  // a stalled hazard is simply re-evaluated next cycle.
  logic bubble;
  always_comb begin
    bubble = flush | (hazardStall & ~stall);
  end

  logic hold;
  always_comb begin
    hold = stall & ~flush;
  end

  // Control path: cleared on a bubble, held on stall, loaded otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validOut        <= 1'b0;
      ALUopOut        <= 2'd0;
      functionCodeOut <= 4'd0;
      ALUSrcOut       <= 1'b0;
      regWriteOut     <= 1'b0;
      memReadOut      <= 1'b0;
      memWriteOut     <= 1'b0;
      memToRegOut     <= 1'b0;
    end else if (bubble) begin
      validOut        <= 1'b0;
      ALUopOut        <= 2'd0;
      functionCodeOut <= 4'd0;
      ALUSrcOut       <= 1'b0;
      regWriteOut     <= 1'b0;
      memReadOut      <= 1'b0;
      memWriteOut     <= 1'b0;
      memToRegOut     <= 1'b0;
    end else if (!hold) begin
      validOut        <= validIn;
      ALUopOut        <= ALUopIn;
      functionCodeOut <= functionCodeIn;
      ALUSrcOut       <= ALUSrcIn;
      regWriteOut     <= regWriteIn;
      memReadOut      <= memReadIn;
      memWriteOut     <= memWriteIn;
      memToRegOut     <= memToRegIn;
    end
  end

  // Data path: a bubble only needs dead control bits, so operands and register
  // numbers keep their previous values rather than toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData1Out <= 16'd0;
      readData2Out <= 16'd0;
      immOut       <= 16'd0;
      rsOut        <= 4'd0;
      rtOut        <= 4'd0;
      rdOut        <= 4'd0;
    end else if (!bubble && !hold) begin
      readData1Out <= readData1In;
      readData2Out <= readData2In;
      immOut       <= immIn;
      rsOut        <= rsIn;
      rtOut        <= rtIn;
      rdOut        <= rdIn;
    end
  end

  // Saturating bubble counter: one increment per bubble edge, even when flush
  // and a hazard coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubbleCount <= 8'd0;
    end else if (bubble && (bubbleCount != 8'hFF)) begin
      bubbleCount <= bubbleCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_idex_register.sv
// Directed bench for idex_register; works with or without IDEX_LOAD_USE_DETECT_EN.
module tb_idex_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        validIn;
  logic [1:0]  ALUopIn;
  logic [3:0]  functionCodeIn;
  logic        ALUSrcIn, regWriteIn, memReadIn, memWriteIn, memToRegIn;
  logic [15:0] readData1In, readData2In, immIn;
  logic [3:0]  rsIn, rtIn, rdIn;
  logic        validOut;
  logic [1:0]  ALUopOut;
  logic [3:0]  functionCodeOut;
  logic        ALUSrcOut, regWriteOut, memReadOut, memWriteOut, memToRegOut;
  logic [15:0] readData1Out, readData2Out, immOut;
  logic [3:0]  rsOut, rtOut, rdOut;
  logic        hazardStall;
  logic [7:0]  bubbleCount;

  int n_cmp = 0;
  int n_err = 0;
  int exp_bc = 0;

  always #5 clk = ~clk;

  idex_register dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .validIn(validIn), .ALUopIn(ALUopIn), .functionCodeIn(functionCodeIn),
    .ALUSrcIn(ALUSrcIn), .regWriteIn(regWriteIn), .memReadIn(memReadIn),
    .memWriteIn(memWriteIn), .memToRegIn(memToRegIn),
    .readData1In(readData1In), .readData2In(readData2In), .immIn(immIn),
    .rsIn(rsIn), .rtIn(rtIn), .rdIn(rdIn),
    .validOut(validOut), .ALUopOut(ALUopOut), .functionCodeOut(functionCodeOut),
    .ALUSrcOut(ALUSrcOut), .regWriteOut(regWriteOut), .memReadOut(memReadOut),
    .memWriteOut(memWriteOut), .memToRegOut(memToRegOut),
    .readData1Out(readData1Out), .readData2Out(readData2Out), .immOut(immOut),
    .rsOut(rsOut), .rtOut(rtOut), .rdOut(rdOut),
    .hazardStall(hazardStall), .bubbleCount(bubbleCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Active edge, then step off it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl_zero(input string tag);
    check({tag, ".validOut"}, validOut, 0);
    check({tag, ".ALUopOut"}, ALUopOut, 0);
    check({tag, ".functionCodeOut"}, functionCodeOut, 0);
    check({tag, ".ctrl"}, {ALUSrcOut, regWriteOut, memReadOut, memWriteOut, memToRegOut}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_ctrl_zero(tag);
    check({tag, ".readData1Out"}, readData1Out, 0);
    check({tag, ".readData2Out"}, readData2Out, 0);
    check({tag, ".immOut"}, immOut, 0);
    check({tag, ".regs"}, {rsOut, rtOut, rdOut}, 0);
    check({tag, ".hazardStall"}, hazardStall, 0);
    check({tag, ".bubbleCount"}, bubbleCount, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    validIn = 1'b0; ALUopIn = 2'd0; functionCodeIn = 4'd0;
    ALUSrcIn = 1'b0; regWriteIn = 1'b0; memReadIn = 1'b0; memWriteIn = 1'b0; memToRegIn = 1'b0;
    readData1In = 16'd0; readData2In = 16'd0; immIn = 16'd0;
    rsIn = 4'd0; rtIn = 4'd0; rdIn = 4'd0;

    // Reset state.
    #2;
    check_all_zero("reset");
    rst = 1'b0;

    // Normal load.
    validIn = 1'b1; ALUopIn = 2'd2; functionCodeIn = 4'b1111;
    ALUSrcIn = 1'b1; regWriteIn = 1'b1;
    readData1In = 16'h1234; readData2In = 16'hABCD; immIn = 16'hFF80;
    rsIn = 4'd1; rtIn = 4'd2; rdIn = 4'd3;
    tick();
    check("load.ALUopOut", ALUopOut, 2);
    check("load.functionCodeOut", functionCodeOut, 15);
    check("load.readData1Out", readData1Out, 16'h1234);
    check("load.readData2Out", readData2Out, 16'hABCD);
    check("load.immOut", immOut, 16'hFF80);
    check("load.validOut", validOut, 1);
    check("load.ctrl", {ALUSrcOut, regWriteOut, memReadOut, memWriteOut, memToRegOut}, 5'b11000);
    check("load.regs", {rsOut, rtOut, rdOut}, 12'h123);
    check("load.bubbleCount", bubbleCount, 0);

    // Stall holds everything for three edges.
    ALUopIn = 2'd1;
    tick();
    check("stall.pre.ALUopOut", ALUopOut, 1);
    stall = 1'b1; ALUopIn = 2'd2; readData1In = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.ALUopOut", ALUopOut, 1);
      check("stall.readData1Out", readData1Out, 16'h1234);
      check("stall.bubbleCount", bubbleCount, 0);
    end

    // Flush beats stall.
    flush = 1'b1;
    tick();
    exp_bc++;
    check_ctrl_zero("flushstall");
    check("flushstall.readData1Out", readData1Out, 16'h1234);
    check("flushstall.bubbleCount", bubbleCount, exp_bc);
    flush = 1'b0; stall = 1'b0;

    // Load-use: load with rt=5, then consumer with rs=5.
    memReadIn = 1'b1; rtIn = 4'd5; rsIn = 4'd1; readData1In = 16'h0042;
    tick();
    memReadIn = 1'b0; rsIn = 4'd5; rtIn = 4'd6; readData1In = 16'h0077;
    #1;
`ifdef IDEX_LOAD_USE_DETECT_EN
    check("lu.hazardStall", hazardStall, 1);
    tick();
    exp_bc++;
    check_ctrl_zero("lu.bubble");
    check("lu.bubble.readData1Out", readData1Out, 16'h0042);
    check("lu.bubble.rtOut", rtOut, 5);
    check("lu.bubble.hazardStall", hazardStall, 0);
    check("lu.bubble.bubbleCount", bubbleCount, exp_bc);
    tick();
`else
    check("lu.hazardStall", hazardStall, 0);
    tick();
`endif
    check("lu.resume.validOut", validOut, 1);
    check("lu.resume.rsOut", rsOut, 5);
    check("lu.resume.readData1Out", readData1Out, 16'h0077);
    check("lu.resume.bubbleCount", bubbleCount, exp_bc);

    // Hazard while stalled is ignored, then taken once stall drops.
    memReadIn = 1'b1; rtIn = 4'd7; rsIn = 4'd2;
    tick();
    memReadIn = 1'b0; rsIn = 4'd7; rtIn = 4'd3; stall = 1'b1;
    tick();
    check("hzstall.validOut", validOut, 1);
    check("hzstall.bubbleCount", bubbleCount, exp_bc);
`ifdef IDEX_LOAD_USE_DETECT_EN
    check("hzstall.hazardStall", hazardStall, 1);
    exp_bc++;
`else
    check("hzstall.hazardStall", hazardStall, 0);
`endif
    stall = 1'b0;
    tick();
    check("hzstall.after.bubbleCount", bubbleCount, exp_bc);
    check("hzstall.after.memReadOut", memReadOut, 0);
    tick();

    // rt=0 is never a hazard.
    memReadIn = 1'b1; rtIn = 4'd0; rsIn = 4'd4;
    tick();
    memReadIn = 1'b0; rsIn = 4'd0; rtIn = 4'd0;
    #1;
    check("rt0.hazardStall", hazardStall, 0);
    tick();
    check("rt0.validOut", validOut, 1);
    check("rt0.bubbleCount", bubbleCount, exp_bc);

    // Flush and hazard on the same edge: one bubble, one increment.
    memReadIn = 1'b1; rtIn = 4'd9; rsIn = 4'd1;
    tick();
    memReadIn = 1'b0; rsIn = 4'd9; rtIn = 4'd1; flush = 1'b1;
    tick();
    exp_bc++;
    flush = 1'b0;
    check_ctrl_zero("flushhz");
    check("flushhz.bubbleCount", bubbleCount, exp_bc);
    check("flushhz.hazardStall", hazardStall, 0);
    tick();
    check("flushhz.next.validOut", validOut, 1);
    check("flushhz.next.bubbleCount", bubbleCount, exp_bc);

    // Saturation after 260 flushes.
    flush = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    check("sat.bubbleCount", bubbleCount, 255);
    flush = 1'b0;

    // Async reset between edges with valid data loaded.
    validIn = 1'b1; ALUopIn = 2'd3; readData1In = 16'hBEEF; rsIn = 4'd6;
    tick();
    check("arst.pre.validOut", validOut, 1);
    check("arst.pre.readData1Out", readData1Out, 16'hBEEF);
    #2 rst = 1'b1;
    #1;
    check_all_zero("arst");
    stall = 1'b1;
    tick();
    check_all_zero("arst.held");
    #2 rst = 1'b0;
    stall = 1'b0;
    tick();
    check("arst.resume.validOut", validOut, 1);
    check("arst.resume.ALUopOut", ALUopOut, 3);
    check("arst.resume.readData1Out", readData1Out, 16'hBEEF);
    check("arst.resume.bubbleCount", bubbleCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idex_register.md
IDEX_REGISTER -- requirements
Module: idex_register

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: stall  in  1  hold all registered contents this cycle.
REQ-004 SHALL have port: flush  in  1  load a bubble this cycle.
REQ-005 SHALL have ports: validIn / validOut  in / out  1  instruction-valid flag.
REQ-006 SHALL have ports: ALUopIn / ALUopOut  in / out  2  ALU op class, consumed by alucontrol.
REQ-007 SHALL have ports: functionCodeIn / functionCodeOut  in / out  4  function field, consumed by alucontrol.
REQ-008 SHALL have ports: ALUSrcIn, regWriteIn, memReadIn, memWriteIn, memToRegIn / matching *Out  in / out  1 each  control bits.
REQ-009 SHALL have ports: readData1In, readData2In, immIn / matching *Out  in / out  16 each  operands and sign-extended immediate.
REQ-010 SHALL have ports: rsIn, rtIn, rdIn / matching *Out  in / out  4 each  register numbers.
REQ-011 SHALL have port: hazardStall  out  1  load-use stall request to PC and IF/ID.
REQ-012 SHALL have port: bubbleCount  out  8  count of inserted bubbles.

Function
REQ-013 SHALL register every *In onto its *Out one cycle after a rising edge with stall=0, flush=0, hazardStall=0.
REQ-014 SHALL apply per-edge priority: rst > flush > stall > hazardStall > normal load.
REQ-015 SHALL, on a bubble (flush, or hazardStall with stall=0), clear validOut, ALUopOut, functionCodeOut and all five control *Out bits to 0.
REQ-016 SHALL, on a bubble, hold readData*/immOut and rs/rt/rdOut at their previous values.
REQ-017 SHALL, with stall=1 and flush=0, hold every output register, including bubbleCount.
REQ-018 SHALL compute hazardStall combinationally: 1 iff validOut & memReadOut & rtOut!=0 & (rtOut==rsIn or rtOut==rtIn) & validIn.
REQ-019 SHALL ignore hazardStall while stall=1; the hazard is re-evaluated on the next cycle.
REQ-020 SHALL limit a load-use hazard to one bubble, since memReadOut is 0 after the bubble.
REQ-021 SHALL increment bubbleCount by 1 on each bubble edge, saturating at 255 (no wrap).
REQ-022 SHALL produce exactly one bubble and one increment when flush and hazardStall are both high on the same edge.

Reset
REQ-023 SHALL, while rst=1, asynchronously force all *Out, validOut and bubbleCount to 0, independent of clk.
REQ-024 SHALL keep hazardStall 0 during reset, because validOut is 0.
REQ-025 SHALL, on reset mid-stall or mid-hazard, discard the pending state and resume normal load on the first edge after rst falls.

Configuration
REQ-026 SHALL, with IDEX_LOAD_USE_DETECT_EN defined, implement REQ-018 to REQ-020.
REQ-027 SHALL, without IDEX_LOAD_USE_DETECT_EN, tie hazardStall to 0; bubbles then come only from flush, and all other behaviour is unchanged.

Verification
REQ-028 SHALL cover normal load: ALUopIn=2, functionCodeIn=4'b1111, readData1In=16'h1234, validIn=1, one edge -> ALUopOut=2, functionCodeOut=15, readData1Out=16'h1234, validOut=1.
REQ-029 SHALL cover stall: load ALUopIn=1, then stall=1 with ALUopIn=2 for 3 edges -> ALUopOut stays 1; bubbleCount unchanged.
REQ-030 SHALL cover flush beating stall: flush=1 and stall=1 together -> validOut=0, ALUopOut=0, regWriteOut=0, readData1Out held, bubbleCount+1.
REQ-031 SHALL cover load-use (macro on): load memReadIn=1, rtIn=5 -> hazardStall=1 when next rsIn=5. The next edge inserts a bubble; hazardStall then drops to 0. With rtIn=0, no hazard occurs.
REQ-032 SHALL cover saturation: 260 consecutive flush edges -> bubbleCount=255.
REQ-033 SHALL cover async reset: assert rst between clock edges with valid data loaded -> all outputs 0 immediately, before the next edge.
